// File: rtl/sm_step_pkg.sv
// Shared state encoding, minimum period and default parameters for the step/direction generator.
// Pure declarations: no logic, no latency, no flow control.
package sm_step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DSETUP,
    ST_HIGH,
    ST_LOW
  } step_state_e;

  localparam int MIN_PERIOD    = 2;

  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_SIZE      = 16;
  localparam int DEF_CNT_W     = 24;
  localparam int DEF_PW_W      = 8;
  localparam int DEF_DIR_SETUP = 4;

endpackage

// File: rtl/sm_step_chan.sv
// One step/direction channel: FSM, phase counter, step counter and shadow period register.
// First step rise DIR_SETUP+1 cycles after start; no backpressure, pulses are never truncated.
module sm_step_chan
  import sm_step_pkg::*;
#(
  parameter int SIZE      = DEF_SIZE,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PW_W      = DEF_PW_W,
  parameter int DIR_SETUP = DEF_DIR_SETUP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trig,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic             dir_in,
  input  logic [SIZE-1:0]  period,
  input  logic [PW_W-1:0]  pulse_w,
  input  logic [CNT_W-1:0] step_count,
  output logic             drv_step,
  output logic             drv_dir,
  output logic             busy,
  output logic             done
);

  // One extra bit on the phase counter so P-1 and P-H never wrap.
  localparam int WW = SIZE + 1;

  step_state_e      state, state_n;
  logic [WW-1:0]    cnt, cnt_n;
  logic [WW-1:0]    lo_len, lo_len_n;
  logic [SIZE-1:0]  shadow, shadow_n;
  logic [SIZE-1:0]  active_per, active_n;
  logic [CNT_W-1:0] remain, remain_n;
  logic             dir_q, dir_n;
  logic             mode_q, mode_n;
  logic             done_q, done_n;
  logic             go_high;

  logic [SIZE-1:0]  p_src;
  logic [WW-1:0]    p_eff, pw_ext, h_eff, l_eff;

  // A trig coinciding with a period load takes effect immediately.
  assign p_src = trig ? period : shadow;

  always_comb begin
    p_eff  = (WW'(p_src) < WW'(MIN_PERIOD)) ? WW'(MIN_PERIOD) : WW'(p_src);
    pw_ext = WW'(pulse_w);
    if (pw_ext == '0) begin
      h_eff = WW'(1);
    end else if (pw_ext > p_eff - WW'(1)) begin
      h_eff = p_eff - WW'(1);
    end else begin
      h_eff = pw_ext;
    end
    l_eff = p_eff - h_eff;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lo_len_n = lo_len;
    remain_n = remain;
    active_n = active_per;
    dir_n    = dir_q;
    mode_n   = mode_q;
    done_n   = 1'b0;
    go_high  = 1'b0;
    shadow_n = trig ? period : shadow;

    unique case (state)
      ST_IDLE: begin
        if (start && enable) begin
          if (mode && (step_count == '0)) begin
            done_n = 1'b1;
          end else begin
            state_n  = ST_DSETUP;
            dir_n    = dir_in;
            mode_n   = mode;
            remain_n = step_count;
            active_n = p_src;
            cnt_n    = WW'(DIR_SETUP - 1);
          end
        end
      end
      ST_DSETUP: begin
        if (cnt == '0) go_high = 1'b1;
        else           cnt_n   = cnt - WW'(1);
      end
      ST_HIGH: begin
        if (cnt == '0) begin
          state_n = ST_LOW;
          cnt_n   = lo_len - WW'(1);
        end else begin
          cnt_n = cnt - WW'(1);
        end
      end
      ST_LOW: begin
        if (cnt == '0) begin
          if ((mode_q && (remain == '0)) || !enable) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else begin
            go_high = 1'b1;
          end
        end else begin
          cnt_n = cnt - WW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Period and width are frozen for the whole step at its rising edge.
    if (go_high) begin
      state_n  = ST_HIGH;
      active_n = p_src;
      cnt_n    = h_eff - WW'(1);
      lo_len_n = l_eff;
      if (mode_q && (remain != '0)) remain_n = remain - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lo_len     <= '0;
      shadow     <= '0;
      active_per <= '0;
      remain     <= '0;
      dir_q      <= 1'b0;
      mode_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      lo_len     <= lo_len_n;
      shadow     <= shadow_n;
      active_per <= active_n;
      remain     <= remain_n;
      dir_q      <= dir_n;
      mode_q     <= mode_n;
      done_q     <= done_n;
    end
  end

  assign drv_step = (state == ST_HIGH);
  assign busy     = (state != ST_IDLE);
  assign drv_dir  = dir_q;
  assign done     = done_q;

endmodule

// File: rtl/sm_step_gen.sv
// Multi-channel stepper step/direction generator: NUM_CH independent channels on flat buses.
// First step rise DIR_SETUP+1 cycles after start; no backpressure, period updates wait for step boundaries.
module sm_step_gen
  import sm_step_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int SIZE      = DEF_SIZE,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PW_W      = DEF_PW_W,
  parameter int DIR_SETUP = DEF_DIR_SETUP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_valid_trig,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       dir_in,
  input  logic [NUM_CH*SIZE-1:0]  period,
  input  logic [NUM_CH*PW_W-1:0]  pulse_w,
  input  logic [NUM_CH*CNT_W-1:0] step_count,
  output logic [NUM_CH-1:0]       drv_step,
  output logic [NUM_CH-1:0]       drv_dir,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sm_step_chan #(
      .SIZE      (SIZE),
      .CNT_W     (CNT_W),
      .PW_W      (PW_W),
      .DIR_SETUP (DIR_SETUP)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .trig       (data_valid_trig),
      .enable     (enable[i]),
      .mode       (mode[i]),
      .start      (start[i]),
      .dir_in     (dir_in[i]),
      .period     (period[i*SIZE +: SIZE]),
      .pulse_w    (pulse_w[i*PW_W +: PW_W]),
      .step_count (step_count[i*CNT_W +: CNT_W]),
      .drv_step   (drv_step[i]),
      .drv_dir    (drv_dir[i]),
      .busy       (busy[i]),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_sm_step_gen.sv
// Bench for sm_step_gen: step-edge timestamps are compared against a timing model built from
// the period/width/enable rules in plain arithmetic.
module tb_sm_step_gen;

  localparam int NUM_CH = 2, SIZE = 16, CNT_W = 24, PW_W = 8, DIR_SETUP = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    data_valid_trig;
  logic [NUM_CH-1:0]       enable, mode, start, dir_in;
  logic [NUM_CH*SIZE-1:0]  period;
  logic [NUM_CH*PW_W-1:0]  pulse_w;
  logic [NUM_CH*CNT_W-1:0] step_count;
  logic [NUM_CH-1:0]       drv_step, drv_dir, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int                rise_q[NUM_CH][$];
  int                width_q[NUM_CH][$];
  int                done_q[NUM_CH][$];
  int                last_rise[NUM_CH];
  logic [NUM_CH-1:0] step_prev = '0;
  logic [NUM_CH-1:0] busy_at_done = '0;

  sm_step_gen #(
    .NUM_CH(NUM_CH), .SIZE(SIZE), .CNT_W(CNT_W), .PW_W(PW_W), .DIR_SETUP(DIR_SETUP)
  ) dut (
    .clk(clk), .rst(rst), .data_valid_trig(data_valid_trig), .enable(enable), .mode(mode),
    .start(start), .dir_in(dir_in), .period(period), .pulse_w(pulse_w), .step_count(step_count),
    .drv_step(drv_step), .drv_dir(drv_dir), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Edge recorder: timestamps step rises, pulse widths and done pulses.
  initial forever begin
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (drv_step[c] && !step_prev[c]) begin
        rise_q[c].push_back(cyc);
        last_rise[c] = cyc;
      end
      if (!drv_step[c] && step_prev[c]) width_q[c].push_back(cyc - last_rise[c]);
      if (done[c]) begin
        done_q[c].push_back(cyc);
        if (busy[c]) busy_at_done[c] = 1'b1;
      end
    end
    step_prev = drv_step;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int eff_p(int per);
    return (per < 2) ? 2 : per;
  endfunction

  function automatic int eff_h(int pw, int p);
    if (pw < 1) return 1;
    if (pw > p - 1) return p - 1;
    return pw;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(int t);
    while (cyc < t) tick();
  endtask

  task automatic clear_mon();
    for (int c = 0; c < NUM_CH; c++) begin
      rise_q[c].delete();
      width_q[c].delete();
      done_q[c].delete();
    end
    busy_at_done = '0;
  endtask

  task automatic setup_ch(int c, int per, int pw, int n);
    period[c*SIZE +: SIZE]      = SIZE'(per);
    pulse_w[c*PW_W +: PW_W]     = PW_W'(pw);
    step_count[c*CNT_W +: CNT_W] = CNT_W'(n);
    data_valid_trig = 1'b1;
    tick();
    data_valid_trig = 1'b0;
  endtask

  // Start request in the current cycle k; returns one cycle later with dir_in flipped.
  task automatic kick(logic [NUM_CH-1:0] chs, logic [NUM_CH-1:0] md, logic [NUM_CH-1:0] dir,
                      output int k);
    k      = cyc;
    start  = chs;
    enable = enable | chs;
    mode   = (mode & ~chs) | (md & chs);
    dir_in = dir;
    tick();
    start  = '0;
    dir_in = ~dir;
  endtask

  task automatic wait_done(int c, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_q[c].size() != 0) ok = 1'b1;
    end
    tick(3);
  endtask

  task automatic test_reset();
    rst = 1'b1; data_valid_trig = 1'b0; enable = '0; mode = '0; start = '0; dir_in = '0;
    period = '0; pulse_w = '0; step_count = '0;
    tick(3);
    checks++; if (drv_step !== '0) begin errors++; $display("FAIL reset_step: got %b want 0", drv_step); end
    checks++; if (drv_dir !== '0) begin errors++; $display("FAIL reset_dir: got %b want 0", drv_dir); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_continuous();
    int k, first, d, n_exp;
    bit ok;
    clear_mon();
    setup_ch(0, 10, 3, 0);
    kick(2'b01, 2'b00, 2'b01, k);
    first = k + 1 + DIR_SETUP;
    checks++; if (busy[0] !== 1'b1 || drv_dir[0] !== 1'b1)
      begin errors++; $display("FAIL cont_start: busy=%b dir=%b want 1 1", busy[0], drv_dir[0]); end
    d = k + 40;
    wait_cyc(d);
    enable[0] = 1'b0;
    wait_done(0, 200, ok);
    n_exp = 1 + (d - first) / 10;
    checks++; if (!ok) begin errors++; $display("FAIL cont_timeout: no done"); end
    checks++; if (rise_q[0].size() != n_exp)
      begin errors++; $display("FAIL cont_count: got %0d want %0d", rise_q[0].size(), n_exp); end
    for (int i = 0; i < rise_q[0].size() && i < n_exp; i++) begin
      checks++; if (rise_q[0][i] != first + 10*i)
        begin errors++; $display("FAIL cont_rise%0d: got %0d want %0d", i, rise_q[0][i], first + 10*i); end
      checks++; if (i >= width_q[0].size() || width_q[0][i] != 3)
        begin errors++; $display("FAIL cont_width%0d: got %0d want 3", i, (i < width_q[0].size()) ? width_q[0][i] : -1); end
    end
    checks++; if (done_q[0].size() != 1 || done_q[0][0] != first + n_exp*10)
      begin errors++; $display("FAIL cont_done: got %0d want %0d", (done_q[0].size() != 0) ? done_q[0][0] : -1, first + n_exp*10); end
  endtask

  task automatic test_counted();
    int k, first;
    bit ok;
    clear_mon();
    setup_ch(0, 6, 2, 5);
    kick(2'b01, 2'b01, 2'b01, k);
    first = k + 1 + DIR_SETUP;
    checks++; if (busy[0] !== 1'b1)
      begin errors++; $display("FAIL cnt_busy: got %b want 1", busy[0]); end
    wait_done(0, 200, ok);
    enable[0] = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL cnt_timeout: no done"); end
    checks++; if (rise_q[0].size() != 5)
      begin errors++; $display("FAIL cnt_count: got %0d want 5", rise_q[0].size()); end
    for (int i = 0; i < rise_q[0].size() && i < 5; i++) begin
      checks++; if (rise_q[0][i] != first + 6*i)
        begin errors++; $display("FAIL cnt_rise%0d: got %0d want %0d", i, rise_q[0][i], first + 6*i); end
      checks++; if (i >= width_q[0].size() || width_q[0][i] != 2)
        begin errors++; $display("FAIL cnt_width%0d: got %0d want 2", i, (i < width_q[0].size()) ? width_q[0][i] : -1); end
    end
    checks++; if (done_q[0].size() != 1 || done_q[0][0] != first + 30)
      begin errors++; $display("FAIL cnt_done: got %0d want %0d", (done_q[0].size() != 0) ? done_q[0][0] : -1, first + 30); end
    checks++; if (busy_at_done[0] !== 1'b0)
      begin errors++; $display("FAIL cnt_busy_at_done: got 1 want 0"); end
    checks++; if (drv_dir[0] !== 1'b1)
      begin errors++; $display("FAIL cnt_dir_hold: got %b want 1", drv_dir[0]); end
    tick(2);
  endtask

  task automatic test_period_change();
    int k, first, exp_r[4];
    bit ok;
    clear_mon();
    setup_ch(1, 8, 3, 0);
    kick(2'b10, 2'b00, 2'b00, k);
    first = k + 1 + DIR_SETUP;
    wait_cyc(first + 3);
    period[SIZE +: SIZE] = SIZE'(20);
    data_valid_trig = 1'b1;
    tick();
    data_valid_trig = 1'b0;
    wait_cyc(first + 50);
    enable[1] = 1'b0;
    wait_done(1, 200, ok);
    exp_r = '{first, first + 8, first + 28, first + 48};
    checks++; if (!ok) begin errors++; $display("FAIL pchg_timeout: no done"); end
    checks++; if (rise_q[1].size() != 4)
      begin errors++; $display("FAIL pchg_count: got %0d want 4", rise_q[1].size()); end
    for (int i = 0; i < rise_q[1].size() && i < 4; i++) begin
      checks++; if (rise_q[1][i] != exp_r[i])
        begin errors++; $display("FAIL pchg_rise%0d: got %0d want %0d", i, rise_q[1][i], exp_r[i]); end
    end
    checks++; if (done_q[1].size() != 1 || done_q[1][0] != first + 68)
      begin errors++; $display("FAIL pchg_done: got %0d want %0d", (done_q[1].size() != 0) ? done_q[1][0] : -1, first + 68); end
  endtask

  task automatic test_enable_drop();
    int k, first;
    bit ok;
    clear_mon();
    setup_ch(1, 10, 5, 0);
    kick(2'b10, 2'b00, 2'b10, k);
    first = k + 1 + DIR_SETUP;
    wait_cyc(first + 21);
    checks++; if (drv_step[1] !== 1'b1)
      begin errors++; $display("FAIL endrop_in_high: got %b want 1", drv_step[1]); end
    enable[1] = 1'b0;
    wait_done(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_timeout: no done"); end
    checks++; if (rise_q[1].size() != 3)
      begin errors++; $display("FAIL endrop_count: got %0d want 3", rise_q[1].size()); end
    for (int i = 0; i < width_q[1].size() && i < 3; i++) begin
      checks++; if (width_q[1][i] != 5)
        begin errors++; $display("FAIL endrop_width%0d: got %0d want 5", i, width_q[1][i]); end
    end
    checks++; if (done_q[1].size() != 1 || done_q[1][0] != first + 30)
      begin errors++; $display("FAIL endrop_done: got %0d want %0d", (done_q[1].size() != 0) ? done_q[1][0] : -1, first + 30); end
  endtask

  task automatic test_reset_mid();
    int k, first;
    bit ok, seen;
    clear_mon();
    setup_ch(0, 10, 5, 2);
    kick(2'b01, 2'b00, 2'b01, k);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (drv_step[0]) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rstmid_no_pulse: step never rose"); end
    rst = 1'b1;
    tick();
    checks++; if (drv_step !== '0 || busy !== '0 || drv_dir !== '0 || done !== '0)
      begin errors++; $display("FAIL rstmid_outputs: step=%b busy=%b dir=%b done=%b want all 0", drv_step, busy, drv_dir, done); end
    rst = 1'b0;
    enable = '0;
    tick(2);
    // No trig since reset: the cleared shadow gives the minimum period.
    clear_mon();
    kick(2'b01, 2'b01, 2'b00, k);
    first = k + 1 + DIR_SETUP;
    wait_done(0, 100, ok);
    enable[0] = 1'b0;
    checks++; if (!ok || rise_q[0].size() != 2 || rise_q[0][0] != first || rise_q[0][1] != first + 2)
      begin errors++; $display("FAIL rstmid_shadow: got %0d rises first at %0d want 2 at %0d,%0d", rise_q[0].size(), (rise_q[0].size() != 0) ? rise_q[0][0] : -1, first, first + 2); end
    checks++; if (done_q[0].size() != 1 || done_q[0][0] != first + 4)
      begin errors++; $display("FAIL rstmid_done: got %0d want %0d", (done_q[0].size() != 0) ? done_q[0][0] : -1, first + 4); end
    tick(2);
  endtask

  task automatic test_two_channels();
    int k, first, d, n0;
    bit ok;
    clear_mon();
    setup_ch(0, 4, 2, 0);
    setup_ch(1, 7, 3, 3);
    kick(2'b11, 2'b10, 2'b01, k);
    first = k + 1 + DIR_SETUP;
    d = k + 40;
    wait_cyc(d);
    enable[0] = 1'b0;
    wait_done(0, 200, ok);
    enable[1] = 1'b0;
    n0 = 1 + (d - first) / 4;
    checks++; if (!ok) begin errors++; $display("FAIL two_timeout: no done on ch0"); end
    checks++; if (drv_dir !== 2'b01) begin errors++; $display("FAIL two_dir: got %b want 01", drv_dir); end
    checks++; if (rise_q[0].size() != n0 || rise_q[1].size() != 3)
      begin errors++; $display("FAIL two_count: got %0d/%0d want %0d/3", rise_q[0].size(), rise_q[1].size(), n0); end
    for (int i = 0; i < rise_q[0].size() && i < n0; i++) begin
      checks++; if (rise_q[0][i] != first + 4*i || width_q[0][i] != 2)
        begin errors++; $display("FAIL two_ch0_%0d: got rise %0d want %0d", i, rise_q[0][i], first + 4*i); end
    end
    for (int i = 0; i < rise_q[1].size() && i < 3; i++) begin
      checks++; if (rise_q[1][i] != first + 7*i || width_q[1][i] != 3)
        begin errors++; $display("FAIL two_ch1_%0d: got rise %0d want %0d", i, rise_q[1][i], first + 7*i); end
    end
    checks++; if (done_q[1].size() != 1 || done_q[1][0] != first + 21)
      begin errors++; $display("FAIL two_ch1_done: got %0d want %0d", (done_q[1].size() != 0) ? done_q[1][0] : -1, first + 21); end
    checks++; if (done_q[0].size() != 1 || done_q[0][0] != first + 4*n0)
      begin errors++; $display("FAIL two_ch0_done: got %0d want %0d", (done_q[0].size() != 0) ? done_q[0][0] : -1, first + 4*n0); end
    tick(2);
  endtask

  task automatic test_edges_random();
    int e_c[5]   = '{0, 1, 0, 1, 0};
    int e_per[5] = '{0, 10, 10, 5, 0};
    int e_pw[5]  = '{3, 0, 50, 2, 0};
    int e_n[5]   = '{3, 2, 2, 0, 0};
    int e_md[5]  = '{1, 1, 1, 1, 0};
    int c, per, pw, n, md, d_off, dir, k, first, p, h, exp_n, exp_done;
    logic exp_busy;
    logic [NUM_CH-1:0] sel;
    bit ok;
    for (int it = 0; it < 15; it++) begin
      if (it < 5) begin
        c = e_c[it]; per = e_per[it]; pw = e_pw[it]; n = e_n[it]; md = e_md[it]; d_off = 12; dir = it % 2;
      end else begin
        c = $urandom_range(0, 1); per = $urandom_range(0, 12); pw = $urandom_range(0, 15);
        n = $urandom_range(0, 5); md = $urandom_range(0, 1); d_off = $urandom_range(2, 40);
        dir = $urandom_range(0, 1);
      end
      clear_mon();
      setup_ch(c, per, pw, n);
      sel = '0; sel[c] = 1'b1;
      kick(sel, (md != 0) ? sel : '0, (dir != 0) ? sel : '0, k);
      first = k + 1 + DIR_SETUP;
      p = eff_p(per);
      h = eff_h(pw, p);
      if (md != 0) exp_n = n;
      else exp_n = (k + d_off >= first) ? 1 + (k + d_off - first) / p : 1;
      exp_busy = !(md != 0 && n == 0);
      exp_done = (exp_n == 0) ? k + 1 : first + exp_n * p;
      checks++; if (busy[c] !== exp_busy)
        begin errors++; $display("FAIL er%0d_busy: got %b want %b", it, busy[c], exp_busy); end
      if (md == 0) begin
        wait_cyc(k + d_off);
        enable[c] = 1'b0;
      end
      wait_done(c, 2000, ok);
      enable[c] = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL er%0d_timeout: no done", it); end
      checks++; if (rise_q[c].size() != exp_n)
        begin errors++; $display("FAIL er%0d_count: got %0d want %0d", it, rise_q[c].size(), exp_n); end
      for (int i = 0; i < rise_q[c].size() && i < exp_n; i++) begin
        checks++; if (rise_q[c][i] != first + p*i)
          begin errors++; $display("FAIL er%0d_rise%0d: got %0d want %0d", it, i, rise_q[c][i], first + p*i); end
        checks++; if (i >= width_q[c].size() || width_q[c][i] != h)
          begin errors++; $display("FAIL er%0d_width%0d: got %0d want %0d", it, i, (i < width_q[c].size()) ? width_q[c][i] : -1, h); end
      end
      checks++; if (done_q[c].size() != 1 || done_q[c][0] != exp_done)
        begin errors++; $display("FAIL er%0d_done: got %0d want %0d", it, (done_q[c].size() != 0) ? done_q[c][0] : -1, exp_done); end
      checks++; if (busy_at_done[c] !== 1'b0)
        begin errors++; $display("FAIL er%0d_busy_at_done: got 1 want 0", it); end
      tick(2);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_counted();
    test_period_change();
    test_enable_drop();
    test_two_channels();
    test_reset_mid();
    test_edges_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_step_gen.md
# sm_step_gen

Multi-channel stepper-motor step/direction generator for the 50 MHz drive path. Each channel emits step pulses with a programmable period and pulse width, either continuously while enabled or for a fixed number of steps. Period updates arrive on the ADC `data_valid_trig` strobe and apply only at step boundaries, so no pulse is ever truncated. The block sits between the motion-control registers/ADC loop and the driver pins.

## Interface
- `NUM_CH`, 2, number of independent channels
- `SIZE`, 16, period width in clock cycles
- `CNT_W`, 24, step-count width
- `PW_W`, 8, pulse-width field width
- `DIR_SETUP`, 4, cycles from direction update to first step edge (≥1)

- `clk`  in  1  50 MHz system clock
- `rst`  in  1  reset: synchronous, active-high
- `data_valid_trig`  in  1  strobe; latches `period` of all channels into shadow registers
- `enable`  in  NUM_CH  per-channel run enable
- `mode`  in  NUM_CH  0 = continuous, 1 = counted
- `start`  in  NUM_CH  one-cycle start request
- `dir_in`  in  NUM_CH  requested direction, sampled on `start`
- `period`  in  NUM_CH*SIZE  step period in cycles; ch i occupies bits [i*SIZE +: SIZE]
- `pulse_w`  in  NUM_CH*PW_W  high-phase width in cycles
- `step_count`  in  NUM_CH*CNT_W  steps to issue in counted mode, sampled on `start`
- `drv_step`  out  NUM_CH  step pulse
- `drv_dir`  out  NUM_CH  direction
- `busy`  out  NUM_CH  channel not IDLE
- `done`  out  NUM_CH  one-cycle pulse at move completion

## Operation
- All outputs reset to 0; reset clears the shadow and active periods and the counters, and forces IDLE. Reset mid-pulse drops `drv_step` on the next edge.
- `data_valid_trig` loads the shadow period. The shadow moves into the active period on every entry to HIGH, and on entry to DSETUP.
- Effective period P = max(active period, 2). Effective high width H = clamp(pulse_w, 1, P−1). pulse_w is sampled at entry to HIGH.
- Per-channel FSM:
  - IDLE: `start` && `enable` → latch `dir_in` to `drv_dir` and load the remaining counter from `step_count` → DSETUP.
    - Counted mode with `step_count`=0: no pulses; `done` pulses on the next cycle; stay IDLE.
    - `start` while `enable`=0: ignored.
  - DSETUP: stays for DIR_SETUP cycles → HIGH.
  - HIGH: `drv_step`=1 for H cycles → LOW. In counted mode the remaining counter decrements on entry to HIGH.
  - LOW: `drv_step`=0 for P−H cycles, then:
    - counted mode and remaining=0 → IDLE with `done`;
    - `enable`=0 → IDLE with `done`;
    - otherwise → HIGH.
- `enable` falling during HIGH: the pulse completes at full width, then LOW completes, then IDLE. No runt pulses.
- `start` while busy: ignored. `dir_in` changes while busy: ignored.
- `data_valid_trig` in the same cycle as entry to HIGH: the new value is used for that step.
- Counters saturate. The period counter is SIZE+1 bits internally, so no wrap-around is possible.

## Timing
- `start` sampled at edge k → `busy`=1 and `drv_dir` valid from k+1.
- First `drv_step` rise at k+1+DIR_SETUP.
- Step-to-step spacing is exactly P cycles. Jitter is 0.
- `done` asserts for one cycle in the cycle after the last LOW phase; `busy` falls in that same cycle.
- Period change latency: it applies from the next step rise after the trig edge.

## Structure
- Package `sm_step_pkg`: FSM state enum (IDLE, DSETUP, HIGH, LOW), the min-period constant 2, and the default parameter values.
- Sub-module `sm_step_chan`: a single channel containing the FSM, counters and shadow register. The top level only generates NUM_CH instances and slices the flat buses.

## Test plan
- Continuous mode, period=10, pulse_w=3, DIR_SETUP=4, start at k → first rise at k+5; rises every 10 cycles; each pulse high 3 cycles.
- Counted mode, step_count=5, period=6, pulse_w=2 → exactly 5 pulses; `done` one cycle after the 5th LOW ends; `busy` low from that cycle.
- `data_valid_trig` with period 20 mid-step while running at period 8 → current step keeps 8 cycles; the next spacing is 20.
- Edge cases: period=0 → treated as 2; pulse_w=0 → treated as 1; pulse_w=50 with period=10 → H=9, L=1; step_count=0 → `done` one cycle after start, no pulses.
- `enable` dropped during HIGH (continuous mode) → full-width pulse, then `done`, then IDLE.
- `rst` asserted during HIGH → all outputs 0 next cycle.
- Two channels: ch0 continuous at period=4, ch1 counted with 3 steps at period=7 → independent streams; ch0 is unaffected by ch1's `done`.
